// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY counters with registered hs/vs/blank/frame_start.
// Define VGA_TIMING_FRAME_COUNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 does not alias to 0
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  // Reset parks on the last pixel of the frame, so qualifiers reset to that decode
  localparam logic HS_RST = !((H_TOTAL - 1) >= H_VISIBLE + H_FP &&
                              (H_TOTAL - 1) <  H_VISIBLE + H_FP + H_SYNC);
  localparam logic VS_RST = !((V_TOTAL - 1) >= V_VISIBLE + V_FP &&
                              (V_TOTAL - 1) <  V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_reg, hc_next;
  logic [9:0] vc_reg, vc_next;
  logic       hs_reg, hs_next;
  logic       vs_reg, vs_next;
  logic       blank_reg, blank_next;
  logic       fs_reg, fs_next;

  always_comb begin
    hc_next = hc_reg + 10'd1;
    vc_next = vc_reg;
    if (hc_reg == H_LAST) begin
      hc_next = 10'd0;
      vc_next = (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
    end
    hs_next    = !(({1'b0, hc_next} >= H_SYNC_BEG) && ({1'b0, hc_next} < H_SYNC_END));
    vs_next    = !(({1'b0, vc_next} >= V_SYNC_BEG) && ({1'b0, vc_next} < V_SYNC_END));
    blank_next = ({1'b0, hc_next} < H_VIS) && ({1'b0, vc_next} < V_VIS);
    fs_next    = (hc_next == 10'd0) && (vc_next == 10'd0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg    <= H_LAST;
      vc_reg    <= V_LAST;
      hs_reg    <= HS_RST;
      vs_reg    <= VS_RST;
      blank_reg <= 1'b0;
      fs_reg    <= 1'b0;
    end else begin
      hc_reg    <= hc_next;
      vc_reg    <= vc_next;
      hs_reg    <= hs_next;
      vs_reg    <= vs_next;
      blank_reg <= blank_next;
      fs_reg    <= fs_next;
    end
  end

  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign blank       = blank_reg;
  assign frame_start = fs_reg;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_cnt_reg;

  // Advances on the same edge that raises frame_start
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= 8'd0;
    end else if (fs_next) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing instance,
// both checked every cycle against a position-from-edge-count model.
module tb_vga_timing_gen;

  localparam int SHV = 6, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHV + SHF + SHS + SHB;   // 13
  localparam int SVT = SVV + SVF + SVS + SVB;   // 9
  localparam int SFT = SHT * SVT;               // 117
  localparam int DFT = 800 * 525;

  logic       clk = 1'b0;
  logic       rst_d, rst_s;
  logic [9:0] x_d, y_d, x_s, y_s;
  logic       hs_d, vs_d, bl_d, fs_d;
  logic       hs_s, vs_s, bl_s, fs_s;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] fc_d, fc_s;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int k_d = 0;
  int k_s = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .vga_clk(clk), .reset_n(rst_d), .DrawX(x_d), .DrawY(y_d),
    .hs(hs_d), .vs(vs_d), .blank(bl_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_s), .DrawX(x_s), .DrawY(y_s),
    .hs(hs_s), .vs(vs_s), .blank(bl_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs after k rising edges since reset release (k=0: in reset)
  function automatic void model(input int hv, hf, hsw, hb, vv, vf, vsw, vb, k,
                                output int x, output int y, output bit h, output bit v,
                                output bit b, output bit f, output int fc);
    int ht, vt, ft, p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    ft = ht * vt;
    p  = (k == 0) ? ft - 1 : (k - 1) % ft;
    x  = p % ht;
    y  = p / ht;
    h  = !(x >= hv + hf && x < hv + hf + hsw);
    v  = !(y >= vv + vf && y < vv + vf + vsw);
    b  = (x < hv) && (y < vv);
    f  = (k != 0) && (p == 0);
    fc = (k == 0) ? 0 : ((k - 1) / ft + 1) % 256;
  endfunction

  always @(posedge clk or negedge rst_d) if (!rst_d) k_d <= 0; else k_d <= k_d + 1;
  always @(posedge clk or negedge rst_s) if (!rst_s) k_s <= 0; else k_s <= k_s + 1;

  int d_bl_cnt, d_hs_cnt, s_bl_cnt, s_vs_cnt, s_hs_cnt, s_fs_cnt;

  always @(negedge clk) begin
    int ex, ey, efc;
    bit eh, ev, eb, ef;

    model(640, 16, 96, 48, 480, 10, 2, 33, k_d, ex, ey, eh, ev, eb, ef, efc);
    check("d_x", x_d, ex);   check("d_y", y_d, ey);
    check("d_hs", hs_d, eh); check("d_vs", vs_d, ev);
    check("d_blank", bl_d, eb); check("d_fs", fs_d, ef);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("d_fc", fc_d, efc);
`endif

    model(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, k_s, ex, ey, eh, ev, eb, ef, efc);
    check("s_x", x_s, ex);   check("s_y", y_s, ey);
    check("s_hs", hs_s, eh); check("s_vs", vs_s, ev);
    check("s_blank", bl_s, eb); check("s_fs", fs_s, ef);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("s_fc", fc_s, efc);
    if (k_s == SFT + 1)       check("s_fc_frame2", fc_s, 2);
    if (k_s == 255 * SFT + 1) check("s_fc_wrap0", fc_s, 0);
    if (k_s == 256 * SFT + 1) check("s_fc_wrap1", fc_s, 1);
`endif

    // Hand-computed pins on the first default line
    if (k_d == 1)   check("d_first_fs", fs_d, 1);
    if (k_d == 640) check("d_x639_blank", bl_d, 1);
    if (k_d == 641) check("d_x640_blank", bl_d, 0);
    if (k_d == 656) check("d_x655_hs", hs_d, 1);
    if (k_d == 657) check("d_x656_hs", hs_d, 0);
    if (k_d == 752) check("d_x751_hs", hs_d, 0);
    if (k_d == 753) check("d_x752_hs", hs_d, 1);
    if (k_d == 800) check("d_x799", x_d, 799);
    if (k_d == 801) begin
      check("d_wrap_x", x_d, 0);
      check("d_wrap_y", y_d, 1);
    end
    if (k_d == 1) begin d_bl_cnt = 0; d_hs_cnt = 0; end
    if (k_d >= 1 && k_d <= 800) begin
      d_bl_cnt += int'(bl_d);
      d_hs_cnt += int'(!hs_d);
    end
    if (k_d == 800) begin
      check("d_line_blank_cnt", d_bl_cnt, 640);
      check("d_line_hs_low_cnt", d_hs_cnt, 96);
    end

    // Per-frame tallies on the small instance
    if (k_s == 1) begin s_bl_cnt = 0; s_vs_cnt = 0; s_hs_cnt = 0; s_fs_cnt = 0; end
    if (k_s >= 1 && k_s <= SFT) begin
      s_bl_cnt += int'(bl_s);
      s_vs_cnt += int'(!vs_s);
      s_hs_cnt += int'(!hs_s);
      s_fs_cnt += int'(fs_s);
    end
    if (k_s == SFT) begin
      check("s_frame_blank_cnt", s_bl_cnt, 24);
      check("s_frame_vs_low_cnt", s_vs_cnt, 26);
      check("s_frame_hs_low_cnt", s_hs_cnt, 27);
      check("s_frame_fs_cnt", s_fs_cnt, 1);
    end
    if (k_s == SFT + 1) check("s_second_frame_fs", fs_s, 1);
  end

  initial begin
    bit found;
    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    $display("phase: reset held 5 clocks");
    check("rst_x", x_d, 799);   check("rst_y", y_d, 524);
    check("rst_hs", hs_d, 1);   check("rst_vs", vs_d, 1);
    check("rst_blank", bl_d, 0); check("rst_fs", fs_d, 0);
    check("rst_s_x", x_s, 12);  check("rst_s_y", y_s, 8);
    @(negedge clk);
    rst_d = 1'b1;
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    check("rel_x", x_d, 0);  check("rel_y", y_d, 0);
    check("rel_blank", bl_d, 1); check("rel_fs", fs_d, 1);
    $display("phase: released, running frames");

    // Run 258 small frames, then reset the small instance at (5,3)
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(negedge clk);
      if (k_s > 258 * SFT && (k_s % SFT) == 3 * SHT + 5 + 1) found = 1'b1;
    end
    check("mid_reset_reached", int'(found), 1);
    #1;
    rst_s = 1'b0;
    #1;
    $display("phase: async reset mid-frame");
    check("mid_x", x_s, 12);   check("mid_y", y_s, 8);
    check("mid_hs", hs_s, 1);  check("mid_vs", vs_s, 1);
    check("mid_blank", bl_s, 0); check("mid_fs", fs_s, 0);
    repeat (2) @(negedge clk);
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_fs", fs_s, 1);
    check("mid_rel_x", x_s, 0);
    check("mid_rel_y", y_s, 0);
    repeat (2 * SFT + 4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
